// File: rtl/pll_clkgen_pkg.sv
// Shared types and constants for the N-channel clock-enable generator.
// The config struct is sized for the widest divide field; the top truncates.
package pll_clkgen_pkg;

  typedef enum logic {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  localparam int unsigned DIV_MIN = 2;
  localparam int CFG_W = 32;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
    logic             en;
  } ch_cfg_t;

endpackage

// File: rtl/pll_clkgen_if.sv
// Valid/ready config port of pll_clkgen_n.
// The master issues requests; the slave answers with ready and a reject pulse.
interface pll_clkgen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic            cfg_en;
  logic            cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div,
    output cfg_phase, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div,
    input  cfg_phase, cfg_en,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: wrapping counter plus registered square/enable flops.
// raw_clk/raw_ce are computed from the next count so they track cnt exactly.
module clkdiv_chan #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  input  logic             en,
  output logic             raw_clk,
  output logic             raw_ce
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             en_r;
  logic             en_nxt;

  always_comb begin
    div_nxt = div_r;
    en_nxt  = en_r;
    if (!en_r) begin
      cnt_nxt = '0;
    end else if (cnt == div_r - ONE) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + ONE;
    end
    if (load) begin
      div_nxt = div;
      en_nxt  = en;
      cnt_nxt = en ? phase : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= DIV_W'(DEFAULT_DIV);
      en_r    <= 1'b1;
      cnt     <= '0;
      raw_clk <= 1'b1;
      raw_ce  <= 1'b1;
    end else begin
      div_r   <= div_nxt;
      en_r    <= en_nxt;
      cnt     <= cnt_nxt;
      raw_clk <= en_nxt && (cnt_nxt < (div_nxt >> 1));
      raw_ce  <= en_nxt && (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/pll_clkgen_n.sv
// N-channel divided clock / clock-enable generator with modelled PLL lock.
// Lock drops for LOCK_CYCLES after reset and after each accepted reconfig.
module pll_clkgen_n
  import pll_clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              refclk,
  input  logic              rst,
  pll_clkgen_if.slave       cfg,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CYCLES - 1);
  localparam logic [LC_W-1:0] LC_ONE = LC_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [LC_W-1:0]   lock_cnt;
  logic [LC_W-1:0]   lock_nxt;
  logic              err_q;
  ch_cfg_t           req;
  logic              hs;
  logic              bad;
  logic              accept;
  logic [NUM_CH-1:0] raw_clk;
  logic [NUM_CH-1:0] raw_ce;

  always_comb begin
    req.div   = CFG_W'(cfg.cfg_div);
    req.phase = CFG_W'(cfg.cfg_phase);
    req.en    = cfg.cfg_en;
  end

  assign hs  = cfg.cfg_valid && (state == LOCKED);
  assign bad = (req.div < CFG_W'(DIV_MIN))
            || (req.phase >= req.div)
            || (CFG_W'(cfg.cfg_ch) >= CFG_W'(NUM_CH));
  assign accept = hs && !bad;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_nxt;
      err_q    <= hs && bad;
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    unique case (state)
      LOCKING: begin
        if (lock_cnt == LC_MAX) begin
          state_nxt = LOCKED;
        end else begin
          lock_nxt = lock_cnt + LC_ONE;
        end
      end
      LOCKED: begin
        if (accept) begin
          state_nxt = LOCKING;
          lock_nxt  = '0;
        end
      end
    endcase
  end

  always_comb begin
    locked        = (state == LOCKED);
    cfg.cfg_ready = (state == LOCKED);
    cfg.cfg_err   = err_q;
  end

  // Counters free-run while unlocked; only the outputs are gated.
  assign outclk = raw_clk & {NUM_CH{locked}};
  assign ce     = raw_ce & {NUM_CH{locked}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (refclk),
      .rst     (rst),
      .load    (accept && (cfg.cfg_ch == CH_W'(i))),
      .div     (req.div[DIV_W-1:0]),
      .phase   (req.phase[DIV_W-1:0]),
      .en      (req.en),
      .raw_clk (raw_clk[i]),
      .raw_ce  (raw_ce[i])
    );
  end

endmodule
